// File: rtl/alu7_pkg.sv
// alu7_pkg: opcodes, width and hex-to-segment table shared by the ALU display slice
package alu7_pkg;
    localparam int WIDTH = 4;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;
    // active-high gfedcba, indexed by hex digit
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex digit to segment decoder with polarity option
module hex_to_7seg
    import alu7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = ACTIVE_LOW ? ~SEG_TABLE[hex] : SEG_TABLE[hex];
endmodule

// File: rtl/show_alu_in_7seg.sv
// show_alu_in_7seg: 4-bit 8-op ALU with registered result/carry shown on one 7-segment digit
module show_alu_in_7seg
    import alu7_pkg::*;
#(
    parameter int WIDTH          = alu7_pkg::WIDTH,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [2:0]       sel,
    input  logic             En,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic [6:0]       seg
);
    logic [WIDTH:0] r;
    // bit WIDTH of r carries the flag: carry, borrow or shifted-out bit
    always_comb begin
        r = '0;
        case (sel)
            OP_ADD: r = {1'b0, in_1} + {1'b0, in_2};
            OP_SUB: r = {1'b0, in_1} - {1'b0, in_2};
            OP_AND: r = {1'b0, in_1 & in_2};
            OP_OR:  r = {1'b0, in_1 | in_2};
            OP_XOR: r = {1'b0, in_1 ^ in_2};
            OP_NOT: r = {1'b0, ~in_1};
            OP_SHL: r = {in_1, 1'b0};
            OP_SHR: r = {in_1[0], 1'b0, in_1[WIDTH-1:1]};
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst)
            {cout, out} <= '0;
        else if (En)
            {cout, out} <= r;
    hex_to_7seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (.hex(out), .seg(seg));
endmodule

// File: tb/tb_show_alu_in_7seg.sv
// tb_show_alu_in_7seg: directed vectors with hand-computed results for the ALU display
module tb_show_alu_in_7seg;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_1, in_2, out;
    logic [2:0] sel;
    logic       En, cout;
    logic [6:0] seg;
    int vectors = 0;
    int miscompares = 0;

    show_alu_in_7seg dut (
        .clk(clk), .rst(rst), .in_1(in_1), .in_2(in_2), .sel(sel),
        .En(En), .out(out), .cout(cout), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s, input logic e);
        @(negedge clk);
        in_1 = a; in_2 = b; sel = s; En = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_1 = 4'd7; in_2 = 4'd5; sel = 3'd0; En = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {3'b0, out}, 7'd0);
        check("rst_cout", {6'b0, cout}, 7'd0);
        check("rst_seg", seg, 7'b1000000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("add_7_5_out", {3'b0, out}, 7'hC);
        check("add_7_5_cout", {6'b0, cout}, 7'd0);
        check("add_7_5_seg", seg, ~7'h39);

        apply(4'd10, 4'd8, 3'd2, 1'b1);
        check("and_out", {3'b0, out}, 7'd8);
        check("and_seg", seg, ~7'h7F);
        apply(4'd5, 4'd10, 3'd3, 1'b1);
        check("or_out", {3'b0, out}, 7'd15);
        check("or_seg", seg, ~7'h71);

        apply(4'd12, 4'd1, 3'd1, 1'b1);
        check("sub_12_1_out", {3'b0, out}, 7'd11);
        check("sub_12_1_cout", {6'b0, cout}, 7'd0);
        apply(4'd0, 4'd1, 3'd1, 1'b1);
        check("sub_0_1_out", {3'b0, out}, 7'd15);
        check("sub_0_1_cout", {6'b0, cout}, 7'd1);

        for (int i = 0; i < 3; i++) begin
            apply(4'd12, 4'd10, 3'd1, 1'b0);
            check("hold_out", {3'b0, out}, 7'd15);
            check("hold_cout", {6'b0, cout}, 7'd1);
            check("hold_seg", seg, ~7'h71);
        end
        apply(4'd12, 4'd10, 3'd1, 1'b1);
        check("sub_12_10_out", {3'b0, out}, 7'd2);
        check("sub_12_10_cout", {6'b0, cout}, 7'd0);
        check("sub_12_10_seg", seg, ~7'h5B);

        apply(4'd15, 4'd15, 3'd0, 1'b1);
        check("add_ovf_out", {3'b0, out}, 7'd14);
        check("add_ovf_cout", {6'b0, cout}, 7'd1);
        apply(4'd9, 4'd0, 3'd6, 1'b1);
        check("shl_out", {3'b0, out}, 7'd2);
        check("shl_cout", {6'b0, cout}, 7'd1);
        apply(4'd9, 4'd0, 3'd7, 1'b1);
        check("shr_out", {3'b0, out}, 7'd4);
        check("shr_cout", {6'b0, cout}, 7'd1);
        check("shr_seg", seg, ~7'h66);
        apply(4'd6, 4'd3, 3'd4, 1'b1);
        check("xor_out", {3'b0, out}, 7'd5);
        check("xor_cout", {6'b0, cout}, 7'd0);
        apply(4'd6, 4'd3, 3'd5, 1'b1);
        check("not_out", {3'b0, out}, 7'd9);
        check("not_seg", seg, ~7'h6F);

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", {3'b0, out}, 7'd0);
        check("async_rst_cout", {6'b0, cout}, 7'd0);
        check("async_rst_seg", seg, 7'b1000000);
        @(posedge clk);
        #1;
        check("rst_held_out", {3'b0, out}, 7'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_out", {3'b0, out}, 7'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
